// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked N-bit ALU with single-cycle ops and iterative MUL/DIVU/REMU
module alu_seq #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Result,
    output logic         Zero,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     result_q, result_d;
    logic             zero_q, zero_d;
    logic [3:0]       op_q, op_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0] alu_res;
    logic         is_iter;
    logic [N-1:0] mul_acc;
    logic [N:0]   rem_sh;
    logic [N:0]   rem_diff;
    logic         no_borrow;

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A + ~B + N'(1);
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(N-1){1'b0}}, (A < B)};
            default: alu_res = '0;
        endcase
    end

    assign is_iter = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);

    // MUL: a_q is the multiplicand, b_q the multiplier, acc_q the product.
    // DIVU/REMU: a_q holds dividend bits shifting out / quotient bits shifting in, acc_q the remainder.
    assign mul_acc   = b_q[0] ? (acc_q + a_q) : acc_q;
    assign rem_sh    = {acc_q, a_q[N-1]};
    assign rem_diff  = rem_sh - {1'b0, b_q};
    assign no_borrow = ~rem_diff[N];

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_iter) begin
                        op_d    = ALUControl;
                        a_d     = A;
                        b_d     = B;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(N);
                        state_d = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = no_borrow ? rem_diff[N-1:0] : rem_sh[N-1:0];
                    a_d   = {a_q[N-2:0], no_borrow};
                end
                // The last iteration and the result write share one edge, giving N+1 latency overall.
                if (cnt_q == CNT_W'(1)) begin
                    result_d = (op_q == OP_DIVU) ? a_d : acc_d;
                    zero_d   = (result_d == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign Result    = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at N=32 and N=8
module tb_alu_seq;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] AND_ = 4'b0010;
    localparam logic [3:0] OR_  = 4'b0011;
    localparam logic [3:0] XOR_ = 4'b0100;
    localparam logic [3:0] SLT  = 4'b0101;
    localparam logic [3:0] SLTU = 4'b0110;
    localparam logic [3:0] MUL  = 4'b1000;
    localparam logic [3:0] DIVU = 4'b1010;
    localparam logic [3:0] REMU = 4'b1011;
    localparam logic [3:0] UNDF = 4'b1111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv, ird, ov, ordy, zero, busy;
    logic [31:0] a, b, res;
    logic [3:0]  op;

    logic        iv8, ird8, ov8, ordy8, zero8, busy8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_seen;

    alu_seq #(.N(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ird),
        .A(a), .B(b), .ALUControl(op),
        .out_valid(ov), .out_ready(ordy),
        .Result(res), .Zero(zero), .busy(busy)
    );

    alu_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ird8),
        .A(a8), .B(b8), .ALUControl(op8),
        .out_valid(ov8), .out_ready(ordy8),
        .Result(res8), .Zero(zero8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit w8, input string tag, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, w8 ? ird8 : ird, 1);
        if (w8) begin
            op8 = o; a8 = x[7:0]; b8 = y[7:0]; iv8 = 1'b1;
        end else begin
            op = o; a = x; b = y; iv = 1'b1;
        end
        @(posedge clk);
        #1;
        iv = 1'b0; iv8 = 1'b0;
        a = 32'hA5A5_5A5A; b = 32'h1234_5678; a8 = 8'h5A; b8 = 8'hC3;
        lat = 1;
        busy_seen = 0;
        @(negedge clk);
        while (!(w8 ? ov8 : ov) && lat < 100) begin
            if (w8 ? busy8 : busy) busy_seen++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, w8 ? {24'd0, res8} : res, exp);
        check({tag, "_zero"}, w8 ? zero8 : zero, exp == 32'd0);
        if (w8 ? ordy8 : ordy) begin
            @(negedge clk);
            check({tag, "_ov_drop"}, w8 ? ov8 : ov, 0);
            check({tag, "_rdy_back"}, w8 ? ird8 : ird, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        iv = 0; a = 0; b = 0; op = 0; ordy = 1;
        iv8 = 0; a8 = 0; b8 = 0; op8 = 0; ordy8 = 1;
        #12;
        check("rst_in_ready", ird, 1);
        check("rst_out_valid", ov, 0);
        check("rst_result", res, 0);
        check("rst_zero", zero, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, "add", ADD, 32'd5, 32'd7, 32'd12, 1);
        run_op(0, "sub_eq", SUB, 32'd9, 32'd9, 32'd0, 1);
        run_op(0, "sub_neg", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
        run_op(0, "and", AND_, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
        run_op(0, "or", OR_, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1);
        run_op(0, "slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op(0, "sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op(0, "xor", XOR_, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1);
        run_op(0, "undef", UNDF, 32'd5, 32'd7, 32'd0, 1);

        run_op(0, "mul", MUL, 32'd123, 32'd456, 32'd56088, 33);
        check("mul_busy_cycles", busy_seen, 32);
        run_op(0, "mul_wrap", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);
        run_op(0, "divu", DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op(0, "remu", REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op(0, "divu_by0", DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 33);
        run_op(0, "remu_by0", REMU, 32'd100, 32'd0, 32'd100, 33);

        ordy = 1'b0;
        run_op(0, "bp_divu", DIVU, 32'd1000, 32'd10, 32'd100, 33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ov_held", ov, 1);
            check("bp_res_held", res, 32'd100);
            check("bp_zero_held", zero, 0);
            check("bp_in_ready", ird, 0);
            op = ADD; a = 32'd1; b = 32'd2; iv = 1'b1;
        end
        @(negedge clk);
        iv = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        check("bp_release_ov", ov, 0);
        check("bp_release_rdy", ird, 1);
        run_op(0, "bp_next_add", ADD, 32'd20, 32'd22, 32'd42, 1);

        @(negedge clk);
        op = MUL; a = 32'd123; b = 32'd456; iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", ird, 1);
        check("midrst_out_valid", ov, 0);
        check("midrst_result", res, 0);
        check("midrst_zero", zero, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, "post_rst_add", ADD, 32'd1, 32'd1, 32'd2, 1);

        run_op(1, "n8_mul", MUL, 32'd15, 32'd17, 32'd255, 9);
        @(negedge clk);
        op8 = DIVU; a8 = 8'd250; b8 = 8'd7; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("n8_midrst_busy", busy8, 0);
        check("n8_midrst_ov", ov8, 0);
        check("n8_midrst_res", res8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, "n8_divu", DIVU, 32'd200, 32'd3, 32'd66, 9);
        run_op(1, "n8_remu_by0", REMU, 32'd200, 32'd0, 32'd200, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked ALU for the RISC-V core. Generalises the combinational ALU: N-bit width, 4-bit op code, more single-cycle ops, and iterative unsigned multiply/divide/remainder.
- Sits between decode/regfile read and writeback. Has valid/ready handshakes on both sides, so the core stalls while a multi-cycle op is running.

Parameters:
N, 32, datapath width in bits (N >= 4)
CNT_W, $clog2(N)+1, width of the iteration counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and op are valid
in_ready  out  1  block can accept an op
A  in  N  operand A
B  in  N  operand B
ALUControl  in  4  operation select
out_valid  out  1  Result and Zero are valid
out_ready  in  1  consumer accepts the result
Result  out  N  registered result
Zero  out  1  1 when Result == 0
busy  out  1  iterative op in progress

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0 the block forces:
  - state=IDLE, in_ready=1
  - out_valid=0, Result=0, Zero=0, busy=0
  - internal registers cleared.
- Reset mid-operation aborts the op with no output; the next op starts clean.
- Op codes, single-cycle (all arithmetic mod 2^N):
  - 0000 ADD
  - 0001 SUB (A + ~B + 1)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT: signed A<B gives 1, else 0
  - 0110 SLTU: unsigned compare
- Op codes, iterative:
  - 1000 MUL: low N bits of the unsigned product
  - 1010 DIVU: unsigned quotient
  - 1011 REMU: unsigned remainder
- Undefined codes: treated as single-cycle with Result=0, Zero=1.
- States: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE. An op is accepted on a cycle where in_valid & in_ready.
- IDLE transitions:
  - Single-cycle op: Result and Zero are registered at the accepting edge. Next state DONE, so out_valid=1 on the following cycle (latency 1).
  - Iterative op: operands latched, counter loaded with N, busy=1, next state BUSY.
- BUSY:
  - One iteration per cycle; the counter decrements each cycle.
  - MUL uses shift-add: a multiplicand shifts left, the multiplier shifts right, and the accumulator adds the multiplicand when the multiplier LSB=1.
  - DIVU/REMU use restoring division: shift the {rem,quot} pair left, trial-subtract B, and set the quotient bit when no borrow.
  - When the counter reaches 0: write Result, compute Zero, busy=0, next state DONE. Accept-to-out_valid latency is exactly N+1 cycles.
- Divide by zero (B=0):
  - DIVU gives all ones; REMU gives A (RISC-V semantics).
  - Still takes the full N+1 cycles, so latency is fixed regardless of data.
- DONE:
  - out_valid=1; Result and Zero are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid falls next cycle and the state returns to IDLE.
  - in_ready rises in the cycle after the handshake, so there is no same-cycle turnaround.
- Protocol:
  - in_valid while in_ready=0 is ignored. The producer must hold its inputs; A, B and ALUControl are not sampled outside acceptance.
  - Operands are latched, so changing A/B during BUSY has no effect.
- Zero always reflects the registered Result.

Test Plan:
1. Reset then ADD, A=5, B=7 -> out_valid 1 cycle after accept, Result=12, Zero=0; SUB 9-9 -> Result=0, Zero=1; SUB 3-5 -> 0xFFFFFFFE.
2. SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same operands -> 0; XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0; code 1111 -> Result=0, Zero=1.
3. MUL 123*456 -> Result=56088 exactly 33 cycles after accept, busy high for cycles 1-32; MUL 0x10000*0x10000 -> Result=0, Zero=1.
4. DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100, each at 33 cycles latency.
5. Backpressure: out_ready=0 for 5 cycles after a DIVU completes -> out_valid, Result and Zero held stable, in_ready=0, a new in_valid is ignored; release -> IDLE, next op executes correctly.
6. Reset mid-BUSY: assert rst_n=0 asynchronously at iteration 10 of a MUL -> outputs immediately at reset values; after release, ADD 1+1 -> Result=2 with latency 1. Repeat with N=8: DIVU 200/3 -> 66 at 9 cycles.
